demux_scan_ctrl: RTL and testbench
==================================

// Module: demux_scan_ctrl
// PURPOSE
//  Upstream controller for the 1-to-8 demux (inputs D, SEL[2:0]; output Y[7:0]).
//  Accepts a stream of single data bits over a valid/ready handshake and
//  distributes them round-robin across the enabled channels.
//  For each bit it drives SEL and D steady for HOLD_CYC clocks, then pulses
//  STROBE so downstream channel registers capture Y.
// PARAMETERS
//  N_CH      8   number of demux outputs; fixed at 8 in this revision
//  SEL_W     3   select width, $clog2(N_CH)
//  HOLD_CYC  4   clocks SEL/D are held per bit; legal range 1..255
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      asynchronous reset, active-high
//  EN_MASK   in   N_CH   channel enables; bit i=1 means channel i is served
//  IN_D      in   1      data bit offered
//  IN_VALID  in   1      IN_D is valid
//  IN_READY  out  1      controller can accept a bit this cycle
//  SEL       out  SEL_W  channel select to the demux (registered)
//  D         out  1      data to the demux (registered)
//  STROBE    out  1      one-cycle capture pulse for the downstream registers
//  BUSY      out  1      high while a bit is being presented
// BEHAVIOUR
//  Clock/reset: single clock CLK; RST asynchronous, active-high.
//  Reset values: SEL=0, D=0, STROBE=0, BUSY=0, IN_READY=0. State=IDLE,
//   round-robin pointer PTR=0, hold counter=0.
//  States: IDLE and HOLD.
//  IDLE:
//   - IN_READY = (state==IDLE) && (EN_MASK != 0), combinational.
//   - D is driven to 0; SEL keeps its last value, so all Y outputs are 0.
//   - Transfer occurs on a rising edge with IN_VALID && IN_READY. At that edge:
//     D <= IN_D; SEL <= PICK; CNT <= HOLD_CYC-1; BUSY <= 1; state <= HOLD.
//   - PICK is the first i with EN_MASK[i]=1, searching PTR, PTR+1, ... mod N_CH.
//   - EN_MASK==0: IN_READY stays 0, no transfer, and the block remains in IDLE.
//  HOLD:
//   - SEL and D are stable; IN_READY=0; CNT decrements by 1 each clock.
//   - STROBE=1 (combinational) exactly in the cycle where CNT==0, including
//     the HOLD_CYC=1 case.
//   - On the edge that ends the CNT==0 cycle: state <= IDLE; BUSY <= 0;
//     D <= 0; PTR <= (SEL+1) mod N_CH.
//  Latency: bit accepted at edge k; SEL/D valid from edge k; STROBE is high
//   during the cycle after edge k+HOLD_CYC-1. Throughput is one bit per
//   HOLD_CYC+1 clocks.
//  EN_MASK is sampled only at the transfer edge. Changes during HOLD do not
//   affect the current bit.
//  PTR wraps from 7 to 0. A mask with a single bit set serves that channel
//   every time.
//  IN_D/IN_VALID seen while IN_READY=0 are ignored; the upstream must hold them.
//  RST asserted during HOLD aborts immediately to reset values, with no STROBE.
//  Counter width is $clog2(HOLD_CYC+1). No arithmetic overflow is possible.
// STRUCTURE
//  Package demux_pkg: N_CH, SEL_W, typedef enum logic {IDLE, HOLD} scan_state_t,
//   and typedef logic [SEL_W-1:0] sel_t.
//  Sub-module rr_pick: combinational next-enabled finder.
//   Inputs: mask, ptr. Outputs: idx, any.
//  Top level: FSM, counter, pointer and output registers; about 150-250 lines.
// TESTING
//  1 Reset: RST=1 mid-run, no clock -> SEL=0, D=0, STROBE=0, BUSY=0, IN_READY=0.
//  2 Round robin: EN_MASK=8'hFF, HOLD_CYC=4, stream 1,1,...,1 (8 bits)
//    -> SEL=0..7 in order; demux Y=1<<SEL at each STROBE; one STROBE every 5 clocks.
//  3 Skip and wrap: EN_MASK=8'b1000_0101, 4 bits
//    -> SEL sequence 0,2,7,0. Bit value 0 -> Y=0 while STROBE=1.
//  4 Empty mask: EN_MASK=0, IN_VALID=1 for 20 clocks
//    -> IN_READY=0 throughout, no STROBE. Set mask 8'h10 -> next SEL=4.
//  5 Mask change in HOLD: accept on SEL=1, change EN_MASK during hold
//    -> SEL/D unchanged until STROBE. Next pick uses the new mask from PTR=2.
//  6 HOLD_CYC=1 and abort: STROBE in the first hold cycle. RST during HOLD
//    -> no STROBE; next accepted bit goes to the lowest enabled channel.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 demux scan controller.
package demux_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = $clog2(N_CH);

    typedef enum logic {
        IDLE,
        HOLD
    } scan_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first enabled channel at or after ptr, wrapping mod N_CH.
module rr_pick
    import demux_pkg::*;
(
    input  logic [N_CH-1:0] mask,
    input  sel_t            ptr,
    output sel_t            idx,
    output logic            any
);

    sel_t cand;
    logic found;

    // Scan ptr, ptr+1, ... and keep the first enabled channel.
    always_comb begin
        idx   = '0;
        any   = |mask;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = sel_t'(32'(ptr) + i);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Upstream controller for a 1-to-8 demux: accepts single bits over valid/ready,
// presents each on SEL/D for HOLD_CYC clocks round-robin across enabled
// channels, and pulses STROBE in the last hold cycle.
module demux_scan_ctrl
    import demux_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] EN_MASK,
    input  logic            IN_D,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output sel_t            SEL,
    output logic            D,
    output logic            STROBE,
    output logic            BUSY
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    sel_t             ptr;
    sel_t             pick_idx;
    logic             pick_any;
    logic             accept;
    logic             last;

    rr_pick u_pick (
        .mask (EN_MASK),
        .ptr  (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Handshake, strobe and next-state decode; ready is masked while in reset.
    always_comb begin
        IN_READY   = (state == IDLE) && pick_any && !RST;
        accept     = IN_READY && IN_VALID;
        last       = (state == HOLD) && (cnt == '0);
        STROBE     = last;
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = HOLD;
            HOLD:    if (last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Output registers, hold counter and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEL  <= '0;
            D    <= 1'b0;
            BUSY <= 1'b0;
            cnt  <= '0;
            ptr  <= '0;
        end else if (accept) begin
            D    <= IN_D;
            SEL  <= pick_idx;
            cnt  <= CNT_LOAD;
            BUSY <= 1'b1;
        end else if (state == HOLD) begin
            if (last) begin
                BUSY <= 1'b0;
                D    <= 1'b0;
                ptr  <= SEL + 1'b1;
            end else begin
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Randomized self-checking bench for demux_scan_ctrl (HOLD_CYC=4 and HOLD_CYC=1).
module tb_demux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [7:0] en_mask;
    logic       in_d, in_valid;
    logic       ready0, ready1, d0, d1, strobe0, strobe1, busy0, busy1;
    logic [2:0] sel0, sel1;

    logic       c_ready, c_d, c_strobe, c_busy;
    logic [2:0] c_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int which = 0;
    int ptr_m [2];

    always #5 clk = ~clk;

    demux_scan_ctrl #(.HOLD_CYC(4)) u_dut4 (
        .CLK(clk), .RST(rst0), .EN_MASK(en_mask), .IN_D(in_d), .IN_VALID(in_valid),
        .IN_READY(ready0), .SEL(sel0), .D(d0), .STROBE(strobe0), .BUSY(busy0)
    );

    demux_scan_ctrl #(.HOLD_CYC(1)) u_dut1 (
        .CLK(clk), .RST(rst1), .EN_MASK(en_mask), .IN_D(in_d), .IN_VALID(in_valid),
        .IN_READY(ready1), .SEL(sel1), .D(d1), .STROBE(strobe1), .BUSY(busy1)
    );

    // Route the instance under test to common observation signals.
    always_comb begin
        c_ready  = (which == 1) ? ready1  : ready0;
        c_sel    = (which == 1) ? sel1    : sel0;
        c_d      = (which == 1) ? d1      : d0;
        c_strobe = (which == 1) ? strobe1 : strobe0;
        c_busy   = (which == 1) ? busy1   : busy0;
    end

    // Reference: first enabled channel searching from p upward, wrapping at 8.
    function automatic int model_pick(logic [7:0] m, int p);
        for (int i = 0; i < 8; i++) begin
            if (m[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] demux_y(logic dv, int s);
        logic [7:0] one;
        one = 8'h01;
        return dv ? (one << s) : 8'h00;
    endfunction

    // One transfer: offer at a negedge, accept on the next edge, check every
    // hold cycle, then check the idle cycle that follows.
    task automatic send_bit(input logic bv, input logic [7:0] mask,
                            input logic [7:0] mask_hold, input int hold);
        int exp_sel;
        logic [7:0] y_exp, y_act;
        en_mask  = mask;
        in_d     = bv;
        in_valid = 1'b1;
        #1;
        exp_sel = model_pick(mask, ptr_m[which]);
        n_cmp++;
        if (c_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL offer_ready: got %b expected 1 (mask %h)", c_ready, mask);
        end
        @(posedge clk);
        #1;
        en_mask  = mask_hold;
        in_d     = 1'($urandom);
        in_valid = 1'($urandom);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({c_sel, c_d, c_busy, c_ready, c_strobe} !==
                {exp_sel[2:0], bv, 1'b1, 1'b0, (c == hold - 1)}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: sel/d/busy/ready/strobe got %0d/%b/%b/%b/%b expected %0d/%b/1/0/%b",
                         c, c_sel, c_d, c_busy, c_ready, c_strobe, exp_sel, bv, (c == hold - 1));
            end
            if (c == hold - 1) begin
                y_exp = demux_y(bv, exp_sel);
                y_act = demux_y(c_d, int'(c_sel));
                n_cmp++;
                if (y_act !== y_exp) begin
                    n_bad++;
                    $display("FAIL demux_y: got %h expected %h", y_act, y_exp);
                end
                in_valid = 1'b0;
            end
        end
        ptr_m[which] = (exp_sel + 1) % 8;
        @(negedge clk);
        n_cmp++;
        if ({c_busy, c_d, c_strobe, c_ready} !== {1'b0, 1'b0, 1'b0, (mask_hold != 0)}) begin
            n_bad++;
            $display("FAIL idle_after: busy/d/strobe/ready got %b/%b/%b/%b expected 0/0/0/%b",
                     c_busy, c_d, c_strobe, c_ready, (mask_hold != 0));
        end
    endtask

    task automatic test_reset;
        which = 0;
        rst0 = 1'b1; rst1 = 1'b1;
        en_mask = 8'hFF; in_d = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({sel0, d0, strobe0, busy0, ready0} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_init: sel/d/strobe/busy/ready got %0d/%b/%b/%b/%b expected all 0",
                     sel0, d0, strobe0, busy0, ready0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        ptr_m[0] = 0;
        // Mid-run reset: accept a bit, then assert reset partway through hold.
        in_d = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst0 = 1'b1;
        #1;
        n_cmp++;
        if ({sel0, d0, strobe0, busy0, ready0} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_midrun: sel/d/strobe/busy/ready got %0d/%b/%b/%b/%b expected all 0",
                     sel0, d0, strobe0, busy0, ready0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        ptr_m[0] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({strobe0, busy0, ready0} !== 3'b001) begin
                n_bad++;
                $display("FAIL reset_after: strobe/busy/ready got %b/%b/%b expected 0/0/1",
                         strobe0, busy0, ready0);
            end
        end
    endtask

    task automatic test_round_robin;
        which = 0;
        for (int i = 0; i < 8; i++) send_bit(1'b1, 8'hFF, 8'hFF, 4);
    endtask

    task automatic test_skip_wrap;
        logic [3:0] bits;
        which = 0;
        bits = 4'b0101;
        for (int i = 0; i < 4; i++) send_bit(bits[i], 8'b1000_0101, 8'b1000_0101, 4);
    endtask

    task automatic test_empty_mask;
        which = 0;
        en_mask = 8'h00; in_valid = 1'b1; in_d = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ready0, strobe0, busy0} !== 3'b000) begin
                n_bad++;
                $display("FAIL empty_mask: ready/strobe/busy got %b/%b/%b expected 0/0/0",
                         ready0, strobe0, busy0);
            end
        end
        send_bit(1'b1, 8'h10, 8'h10, 4);
    endtask

    task automatic test_mask_change;
        which = 0;
        send_bit(1'b0, 8'h01, 8'h01, 4);
        send_bit(1'b1, 8'h02, 8'h09, 4);
        send_bit(1'b1, 8'h09, 8'h09, 4);
    endtask

    task automatic test_random;
        logic [7:0] m, mh;
        which = 0;
        for (int i = 0; i < 30; i++) begin
            m  = 8'($urandom_range(1, 255));
            mh = ($urandom_range(0, 3) == 0) ? m : 8'($urandom_range(1, 255));
            send_bit(1'($urandom), m, mh, 4);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                n_cmp++;
                if ({busy0, strobe0} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL random_gap: busy/strobe got %b/%b expected 0/0", busy0, strobe0);
                end
            end
        end
    endtask

    task automatic test_hold1;
        which = 1;
        rst0 = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        ptr_m[1] = 0;
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1);
        // Abort inside the only hold cycle: no strobe may appear.
        en_mask = 8'h24; in_d = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 rst1 = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({strobe1, busy1, d1, sel1} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_hold1: strobe/busy/d/sel got %b/%b/%b/%0d expected 0/0/0/0",
                     strobe1, busy1, d1, sel1);
        end
        rst1 = 1'b0;
        ptr_m[1] = 0;
        send_bit(1'b1, 8'h24, 8'h24, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_empty_mask();
        test_mask_change();
        test_random();
        test_hold1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
